adpll_lock_monitor: RTL
=======================

# adpll_lock_monitor

Per-node lock detector sitting directly downstream of a network ADPLL node. It consumes the node's signed phase-error output and its divided-by-8 generated clock, and produces a debounced lock flag, a reference-loss flag and a peak-error register. Top-level test builds drive these to LEDs and debug headers. One instance sits beside each ADPLL node in the mesh, clocked from the same fast fabric clock as the loop filter.

## Interface
Parameters:
- PDET_WIDTH, 8: width of the signed two's-complement phase error.
- LOCK_COUNT, 16: consecutive in-window samples needed to declare lock. Must be ≥2.
- UNLOCK_COUNT, 4: consecutive out-of-window samples needed to drop lock. Must be ≥2.
- REF_TIMEOUT, 1024: fpga_clk_i cycles without a sample strobe before reference loss is flagged.
- CNT_WIDTH, 8: width of the sample counter. Must hold max(LOCK_COUNT, UNLOCK_COUNT).

Ports:
- fpga_clk_i  in  1  fabric clock, same domain as the ADPLL loop.
- reset_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  monitor enable; low forces a synchronous clear.
- ref_i  in  1  node's gen_div8 clock (asynchronous); its rising edge triggers a sample.
- error_i  in  PDET_WIDTH  signed phase error (fpga_clk_i domain), stable ≥4 cycles after each ref_i rise.
- thresh_i  in  PDET_WIDTH  unsigned lock window; a sample is good if |error| ≤ thresh_i.
- clear_peak_i  in  1  single-cycle pulse that clears peak_err_o.
- locked_o  out  1  high in LOCKED or LOSING.
- ref_lost_o  out  1  reference timeout flag.
- lock_event_o  out  1  one-cycle pulse on entry to LOCKED from ACQUIRING.
- unlock_event_o  out  1  one-cycle pulse on exit to UNLOCKED from LOCKED or LOSING, whether by count or by timeout.
- state_o  out  2  FSM state encoding.
- peak_err_o  out  PDET_WIDTH-1  maximum |error| since the last clear.

## Operation
- **Synchroniser:** ref_i passes through flops s1→s2→s3. The strobe is s2 & ~s3.
- **Magnitude:** mag = |error_i|, computed in PDET_WIDTH-1 bits. The most negative value (−2^(PDET_WIDTH-1)) saturates to 2^(PDET_WIDTH-1)−1. The comparison mag ≤ thresh_i is unsigned, zero-extended.
- **States:** UNLOCKED=0, ACQUIRING=1, LOCKED=2, LOSING=3.
- **UNLOCKED:**
  - good sample → ACQUIRING, cnt=1.
  - bad sample → stay, cnt=0.
- **ACQUIRING:**
  - good sample → cnt+1; if the new cnt equals LOCK_COUNT → LOCKED, cnt=0, lock_event_o.
  - bad sample → UNLOCKED, cnt=0.
- **LOCKED:**
  - bad sample → LOSING, cnt=1.
  - good sample → stay.
- **LOSING:**
  - bad sample → cnt+1; if the new cnt equals UNLOCK_COUNT → UNLOCKED, cnt=0, unlock_event_o.
  - good sample → LOCKED, cnt=0, no event.
- **Timeout:**
  - tcnt resets to 0 on every strobe and otherwise increments, saturating.
  - When tcnt reaches REF_TIMEOUT−1: ref_lost_o=1, state→UNLOCKED, cnt=0. unlock_event_o pulses if the previous state was LOCKED or LOSING.
  - ref_lost_o clears on the next strobe; that strobe's sample is also evaluated normally.
- **Peak:** on each sample, peak = max(peak, mag).
  - clear_peak_i without a sample → peak=0.
  - clear_peak_i coincident with a sample's update cycle → peak=mag of that sample.
- **enable_i low:** state=UNLOCKED, cnt=0, tcnt=0, ref_lost_o=0, event pulses suppressed. Peak is held, and clear_peak_i still acts. The synchroniser keeps running.

## Timing
- **Reset values:** every output is 0 and state is UNLOCKED. The s1–s3, cnt and tcnt registers are all 0.
- **Cycle numbering** (fpga_clk_i edges, cycle S = strobe high):
  - S: error_i is registered together with the strobe (err_q, smp_q).
  - S+1: mag/good computed from err_q and registered (good_q, mag_q, vld_q).
  - S+2: FSM, cnt, peak_err_o, locked_o and event pulses update.
- **Latency:** from the first ref_i sample-high to the strobe is 2–3 cycles. From strobe to locked_o/peak_err_o update is 2 cycles.
- **Event pulses:** exactly one cycle wide, registered.
- **Timeout vs sample:** if the timeout cycle coincides with vld_q, the timeout wins, and the pending sample is applied starting from UNLOCKED on that same edge.
- **Reset mid-operation:** immediate asynchronous return to the reset values. No event pulse.

## Test plan
- **Lock acquisition:** thresh_i=4, error_i=+3, ref_i at 32-cycle period, 16 edges → locked_o rises 2 cycles after the 16th strobe; lock_event_o is a single pulse; state_o=2.
- **Window boundary:** error_i=−4 and +4 with thresh_i=4 count as good; error_i=−5 is bad. error_i=8'h80 → peak_err_o=127.
- **Debounce:** locked; 3 bad samples (error_i=20) then 1 good → state_o goes 3 then 2; locked_o stays 1; no unlock_event_o. Four bad samples → locked_o=0 and unlock_event_o pulses once.
- **Reference loss:** locked; stop ref_i → after REF_TIMEOUT cycles ref_lost_o=1, locked_o=0, unlock_event_o pulses. Restart ref_i → ref_lost_o clears on the first strobe; acquisition restarts with cnt=1.
- **Peak clear race:** peak=50; assert clear_peak_i on a sample's update cycle with |error|=7 → peak_err_o=7.
- **Reset and enable:** assert reset_i mid-LOCKED → all outputs 0 immediately. Drop enable_i while in ACQUIRING → state_o=0 next cycle; peak_err_o is unchanged.

Source files
------------

// File: rtl/adpll_lock_monitor.sv
// Lock detector for one ADPLL node: synchronises the node's divided clock, windows the
// phase error, debounces lock/unlock, flags reference loss and tracks the peak |error|.
module adpll_lock_monitor #(
  parameter int PDET_WIDTH   = 8,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int REF_TIMEOUT  = 1024,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  ref_i,
  input  logic [PDET_WIDTH-1:0] error_i,
  input  logic [PDET_WIDTH-1:0] thresh_i,
  input  logic                  clear_peak_i,
  output logic                  locked_o,
  output logic                  ref_lost_o,
  output logic                  lock_event_o,
  output logic                  unlock_event_o,
  output logic [1:0]            state_o,
  output logic [PDET_WIDTH-2:0] peak_err_o
);

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    ACQUIRING = 2'd1,
    LOCKED    = 2'd2,
    LOSING    = 2'd3
  } state_t;

  localparam int TCNT_W = $clog2(REF_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0]     TCNT_MAX = TCNT_W'(REF_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0]  LOCK_N   = CNT_WIDTH'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0]  UNLOCK_N = CNT_WIDTH'(UNLOCK_COUNT);
  localparam logic [PDET_WIDTH-1:0] ERR_MIN  = {1'b1, {(PDET_WIDTH-1){1'b0}}};

  logic                  s1, s2, s3;
  logic                  strobe;
  logic                  smp_q, vld_q, good_q;
  logic [PDET_WIDTH-1:0] err_q;
  logic [PDET_WIDTH-1:0] err_neg;
  logic [PDET_WIDTH-2:0] mag, mag_q;
  logic                  good;
  logic [CNT_WIDTH-1:0]  cnt, cnt_inc;
  logic [TCNT_W-1:0]     tcnt;
  logic                  timeout;
  state_t                state;

  assign strobe   = s2 & ~s3;
  assign cnt_inc  = cnt + CNT_WIDTH'(1);
  assign timeout  = (tcnt == TCNT_MAX);
  assign state_o  = state;
  assign locked_o = (state == LOCKED) || (state == LOSING);

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ref_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // |error| in PDET_WIDTH-1 bits; the most negative code saturates to all ones
  always_comb begin
    err_neg = '0 - err_q;
    if (!err_q[PDET_WIDTH-1])   mag = err_q[PDET_WIDTH-2:0];
    else if (err_q == ERR_MIN)  mag = '1;
    else                        mag = err_neg[PDET_WIDTH-2:0];
    good = ({1'b0, mag} <= thresh_i);
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      smp_q  <= 1'b0;
      err_q  <= '0;
      vld_q  <= 1'b0;
      good_q <= 1'b0;
      mag_q  <= '0;
    end else begin
      smp_q <= strobe;
      if (strobe) err_q <= error_i;
      vld_q <= smp_q;
      if (smp_q) begin
        good_q <= good;
        mag_q  <= mag;
      end
    end
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state          <= UNLOCKED;
      cnt            <= '0;
      tcnt           <= '0;
      ref_lost_o     <= 1'b0;
      lock_event_o   <= 1'b0;
      unlock_event_o <= 1'b0;
      peak_err_o     <= '0;
    end else begin
      lock_event_o   <= 1'b0;
      unlock_event_o <= 1'b0;

      if (vld_q && enable_i)
        peak_err_o <= (clear_peak_i || (mag_q > peak_err_o)) ? mag_q : peak_err_o;
      else if (clear_peak_i)
        peak_err_o <= '0;

      if (!enable_i) begin
        state      <= UNLOCKED;
        cnt        <= '0;
        tcnt       <= '0;
        ref_lost_o <= 1'b0;
      end else begin
        if (strobe)        tcnt <= '0;
        else if (!timeout) tcnt <= tcnt + TCNT_W'(1);

        if (strobe)       ref_lost_o <= 1'b0;
        else if (timeout) ref_lost_o <= 1'b1;

        // Timeout overrides the state; a coincident sample is applied as if from UNLOCKED
        if (timeout) begin
          if (state == LOCKED || state == LOSING) unlock_event_o <= 1'b1;
          if (vld_q && good_q) begin
            state <= ACQUIRING;
            cnt   <= CNT_WIDTH'(1);
          end else begin
            state <= UNLOCKED;
            cnt   <= '0;
          end
        end else if (vld_q) begin
          case (state)
            UNLOCKED: begin
              if (good_q) begin
                state <= ACQUIRING;
                cnt   <= CNT_WIDTH'(1);
              end else begin
                cnt <= '0;
              end
            end
            ACQUIRING: begin
              if (!good_q) begin
                state <= UNLOCKED;
                cnt   <= '0;
              end else if (cnt_inc == LOCK_N) begin
                state        <= LOCKED;
                cnt          <= '0;
                lock_event_o <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
            LOCKED: begin
              if (!good_q) begin
                state <= LOSING;
                cnt   <= CNT_WIDTH'(1);
              end
            end
            LOSING: begin
              if (good_q) begin
                state <= LOCKED;
                cnt   <= '0;
              end else if (cnt_inc == UNLOCK_N) begin
                state          <= UNLOCKED;
                cnt            <= '0;
                unlock_event_o <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
            default: begin
              state <= UNLOCKED;
              cnt   <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule
